z3_master_cycle_seq: RTL and testbench

// - Sequences one Zorro III master data cycle per local request once the bus arbiter has granted us the bus (MYBUS_n low).
// - Sits between the SCSI-side DMA request interface and the Z3 control pins.
// - Drives FCS_n, DS_n, DOE and READ, waits for DTACK_n or BERR_n with a watchdog, acks the requester, then releases FCS_n so the arbiter can drop MYBUS_n.

---
 rtl/z3_master_cycle_seq_pkg.sv | 38 +++
 rtl/z3_master_cycle_seq_if.sv | 29 ++
 rtl/z3_master_cycle_seq_watchdog.sv | 31 +++
 rtl/z3_master_cycle_seq.sv | 142 ++++++++++++++
 tb/tb_z3_master_cycle_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z3_master_cycle_seq_pkg.sv
// z3_pkg: shared types and the byte-lane decode for the Z3 master.
// Lanes are big-endian: DS_n[3] strobes D31..24.
package z3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WAIT,
    ST_TERM,
    ST_RECOV,
    ST_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  // Returns {misaligned, ds_n[3:0]}; misaligned results carry no lanes.
  function automatic logic [4:0] z3_lanes(
    input logic [1:0] siz,
    input logic [1:0] sa
  );
    logic [4:0] r;
    r = 5'b1_1111;
    unique case (1'b1)
      (siz == SZ_BYTE): r = {1'b0, ~(4'b1000 >> sa)};
      (siz == SZ_WORD): begin
        if (sa[0]) r = 5'b1_1111;
        else if (sa[1]) r = 5'b0_1100;
        else r = 5'b0_0011;
      end
      default: r = (sa != 2'd0) ? 5'b1_1111 : 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/z3_master_cycle_seq_if.sv
// z3_master_cycle_seq_if: request side and Z3 control pins.
// master = the sequencer, slave = requester/bus model.
interface z3_master_cycle_seq_if;
  logic       MYBUS_n;
  logic       SREQ;
  logic       SWRITE;
  logic [1:0] SSIZ;
  logic [1:0] SA;
  logic       DTACK_n;
  logic       BERR_n;
  logic       AOE;
  logic       FCS_n;
  logic [3:0] DS_n;
  logic       DOE;
  logic       READ;
  logic       SACK;
  logic       SERR;
  logic       BUSY;

  modport master (
    input  MYBUS_n, SREQ, SWRITE, SSIZ, SA, DTACK_n, BERR_n,
    output AOE, FCS_n, DS_n, DOE, READ, SACK, SERR, BUSY
  );

  modport slave (
    output MYBUS_n, SREQ, SWRITE, SSIZ, SA, DTACK_n, BERR_n,
    input  AOE, FCS_n, DS_n, DOE, READ, SACK, SERR, BUSY
  );
endinterface

// File: rtl/z3_master_cycle_seq_watchdog.sv
// z3_cycle_watchdog: saturating wait-state counter.
// expired is high once TIMEOUT_CYC wait cycles have elapsed.
module z3_cycle_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins; count only while enabled and not saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (enable && cnt_q != LIMIT) cnt_d = cnt_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);
endmodule

// File: rtl/z3_master_cycle_seq.sv
// z3_master_cycle_seq: one Zorro III master data cycle per request.
// All pin outputs are registered from the next state.
module z3_master_cycle_seq
  import z3_pkg::*;
#(
  parameter int ADDR_SETUP  = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int RECOVER_MIN = 1
) (
  input logic                   CLK,
  input logic                   RESET,
  z3_master_cycle_seq_if.master bus
);
  localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
  localparam int RW = (RECOVER_MIN > 1) ? $clog2(RECOVER_MIN) : 1;
  localparam logic [SW-1:0] S_LAST =
    SW'((ADDR_SETUP > 1) ? ADDR_SETUP - 1 : 0);
  localparam logic [RW-1:0] R_LAST =
    RW'((RECOVER_MIN > 1) ? RECOVER_MIN - 1 : 0);

  state_e        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [3:0]    lanes_q, lanes_d;
  logic          aoe_q, aoe_d;
  logic          fcs_n_q, fcs_n_d;
  logic [3:0]    ds_n_q, ds_n_d;
  logic          doe_q, doe_d;
  logic          read_q, read_d;
  logic          sack_q, sack_d;
  logic          serr_q, serr_d;
  logic          busy_q, busy_d;
  logic [4:0]    dec;
  logic          wd_exp;

  assign dec = z3_lanes(bus.SSIZ, bus.SA);

  z3_cycle_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (state_q != ST_WAIT),
    .enable (state_q == ST_WAIT),
    .expired(wd_exp)
  );

  // Next state, counters and registered pin values.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    rcnt_d  = '0;
    lanes_d = lanes_q;
    read_d  = read_q;
    sack_d  = 1'b0;
    serr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        read_d = 1'b1;
        if (bus.SREQ && dec[4]) begin
          state_d = ST_DONE;
          serr_d  = 1'b1;
        end else if (bus.SREQ && !bus.MYBUS_n) begin
          state_d = ST_ADDR;
          scnt_d  = '0;
          lanes_d = dec[3:0];
          read_d  = !bus.SWRITE;
        end
      end
      ST_ADDR: begin
        if (scnt_q == S_LAST) state_d = ST_STRB;
        else scnt_d = scnt_q + SW'(1);
      end
      ST_STRB: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.BERR_n) begin
          state_d = ST_TERM;
          serr_d  = 1'b1;
        end else if (!bus.DTACK_n) begin
          state_d = ST_TERM;
          sack_d  = 1'b1;
        end else if (wd_exp) begin
          state_d = ST_TERM;
          serr_d  = 1'b1;
        end
      end
      ST_TERM: state_d = ST_RECOV;
      ST_RECOV: begin
        rcnt_d = (rcnt_q == R_LAST) ? rcnt_q : rcnt_q + RW'(1);
        if (rcnt_q == R_LAST && bus.DTACK_n && bus.BERR_n)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    aoe_d   = state_d inside {ST_ADDR, ST_STRB, ST_WAIT};
    fcs_n_d = !(state_d inside {ST_STRB, ST_WAIT});
    doe_d   = (state_d == ST_WAIT);
    ds_n_d  = doe_d ? lanes_q : 4'hF;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any cycle in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      rcnt_q  <= '0;
      lanes_q <= 4'hF;
      aoe_q   <= 1'b0;
      fcs_n_q <= 1'b1;
      ds_n_q  <= 4'hF;
      doe_q   <= 1'b0;
      read_q  <= 1'b1;
      sack_q  <= 1'b0;
      serr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      rcnt_q  <= rcnt_d;
      lanes_q <= lanes_d;
      aoe_q   <= aoe_d;
      fcs_n_q <= fcs_n_d;
      ds_n_q  <= ds_n_d;
      doe_q   <= doe_d;
      read_q  <= read_d;
      sack_q  <= sack_d;
      serr_q  <= serr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.AOE   = aoe_q;
  assign bus.FCS_n = fcs_n_q;
  assign bus.DS_n  = ds_n_q;
  assign bus.DOE   = doe_q;
  assign bus.READ  = read_q;
  assign bus.SACK  = sack_q;
  assign bus.SERR  = serr_q;
  assign bus.BUSY  = busy_q;
endmodule

// File: tb/tb_z3_master_cycle_seq.sv
// tb_z3_master_cycle_seq: directed and random Z3 master cycles.
// Edge 0 is the first CLK edge that sees SREQ with the bus granted.
module tb_z3_master_cycle_seq;
  localparam int AS = 2;
  localparam int TO = 15;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  z3_master_cycle_seq_if bus();

  z3_master_cycle_seq #(
    .ADDR_SETUP (AS),
    .TIMEOUT_CYC(TO),
    .RECOVER_MIN(1)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         fcs_edge;
    int         resp_edge;
    int         idle_edge;
    int         sack_n;
    int         serr_n;
    logic [3:0] ds_wait;
    logic       read_wait;
    logic       doe_wait;
    logic       aoe_wait;
    logic       aoe_e0;
    logic       pre_bad;
    logic [6:0] rel_vec;
  } obs_t;

  // kind: 0 DTACK, 1 BERR, 2 both together, 3 no answer
  task automatic do_txn(
    input  logic [1:0] siz,
    input  logic [1:0] sa,
    input  logic       wr,
    input  int         kind,
    input  int         dly,
    input  int         hold,
    input  int         gdly,
    output obs_t       o
  );
    bit resp;
    int rel;
    o.fcs_edge  = -1;
    o.resp_edge = -1;
    o.idle_edge = -1;
    o.sack_n    = 0;
    o.serr_n    = 0;
    o.ds_wait   = 4'hx;
    o.read_wait = 1'bx;
    o.doe_wait  = 1'b0;
    o.aoe_wait  = 1'b0;
    o.aoe_e0    = 1'b0;
    o.pre_bad   = 1'b0;
    o.rel_vec   = 7'hx;
    resp = 1'b0;
    rel  = -1;
    @(negedge clk);
    bus.SREQ    = 1'b1;
    bus.SSIZ    = siz;
    bus.SA      = sa;
    bus.SWRITE  = wr;
    bus.DTACK_n = 1'b1;
    bus.BERR_n  = 1'b1;
    bus.MYBUS_n = (gdly > 0);
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      if (bus.FCS_n !== 1'b1 || bus.BUSY !== 1'b0)
        o.pre_bad = 1'b1;
    end
    bus.MYBUS_n = 1'b0;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      if (e == 0) o.aoe_e0 = bus.AOE;
      if (o.fcs_edge < 0 && bus.FCS_n === 1'b0) o.fcs_edge = e;
      if (bus.DOE === 1'b1 && o.doe_wait !== 1'b1) begin
        o.doe_wait  = 1'b1;
        o.ds_wait   = bus.DS_n;
        o.read_wait = bus.READ;
        o.aoe_wait  = bus.AOE;
      end
      if (bus.SACK === 1'b1) o.sack_n++;
      if (bus.SERR === 1'b1) o.serr_n++;
      if (!resp && (bus.SACK === 1'b1 || bus.SERR === 1'b1)) begin
        resp        = 1'b1;
        o.resp_edge = e;
        o.rel_vec   = {bus.FCS_n, bus.DS_n, bus.DOE, bus.AOE};
        bus.SREQ    = 1'b0;
        rel         = e + hold;
      end
      if (resp && e == rel) begin
        bus.DTACK_n = 1'b1;
        bus.BERR_n  = 1'b1;
      end
      if (!resp && o.fcs_edge >= 0 && e == o.fcs_edge + dly) begin
        if (kind == 0 || kind == 2) bus.DTACK_n = 1'b0;
        if (kind == 1 || kind == 2) bus.BERR_n = 1'b0;
      end
      if (resp && e > o.resp_edge && bus.BUSY === 1'b0) begin
        o.idle_edge = e;
        break;
      end
    end
    bus.SREQ    = 1'b0;
    bus.MYBUS_n = 1'b1;
    bus.DTACK_n = 1'b1;
    bus.BERR_n  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.AOE, bus.FCS_n, bus.DS_n, bus.DOE, bus.READ}
        !== 8'b0_1_1111_0_1)
      $display("FAIL reset_pins got %b want 01111101",
               {bus.AOE, bus.FCS_n, bus.DS_n, bus.DOE, bus.READ});
    else n_pass++;
    n_checks++;
    if ({bus.SACK, bus.SERR, bus.BUSY} !== 3'b000)
      $display("FAIL reset_status got %b want 000",
               {bus.SACK, bus.SERR, bus.BUSY});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_long_read();
    obs_t o;
    do_txn(2'd2, 2'd0, 1'b0, 0, 3, 0, 0, o);
    n_checks++;
    if (o.ds_wait !== 4'b0000)
      $display("FAIL long_ds got %b want 0000", o.ds_wait);
    else n_pass++;
    n_checks++;
    if (o.read_wait !== 1'b1)
      $display("FAIL long_read got %b want 1", o.read_wait);
    else n_pass++;
    n_checks++;
    if (o.sack_n !== 1 || o.serr_n !== 0)
      $display("FAIL long_ack got sack=%0d serr=%0d want 1/0",
               o.sack_n, o.serr_n);
    else n_pass++;
    n_checks++;
    if (o.resp_edge !== AS + 1 + 3)
      $display("FAIL long_lat got %0d want %0d", o.resp_edge, AS + 4);
    else n_pass++;
    n_checks++;
    if (o.rel_vec[6] !== 1'b1)
      $display("FAIL long_term_fcs got %b want 1", o.rel_vec[6]);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    obs_t o;
    do_txn(2'd0, 2'd2, 1'b1, 0, 2, 0, 0, o);
    n_checks++;
    if ({o.ds_wait, o.read_wait, o.doe_wait} !== 6'b1101_0_1)
      $display("FAIL byte_wr got %b want 110101",
               {o.ds_wait, o.read_wait, o.doe_wait});
    else n_pass++;
    n_checks++;
    if (o.sack_n !== 1)
      $display("FAIL byte_wr_sack got %0d want 1", o.sack_n);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_txn(2'd1, 2'd1, 1'b0, 0, 1, 0, 0, o);
    n_checks++;
    if (o.serr_n !== 1 || o.sack_n !== 0)
      $display("FAIL misal_resp got serr=%0d sack=%0d want 1/0",
               o.serr_n, o.sack_n);
    else n_pass++;
    n_checks++;
    if (o.fcs_edge !== -1 || o.doe_wait !== 1'b0)
      $display("FAIL misal_bus got fcs_edge=%0d doe=%b want -1/0",
               o.fcs_edge, o.doe_wait);
    else n_pass++;
    n_checks++;
    if (o.resp_edge !== 0)
      $display("FAIL misal_lat got %0d want 0", o.resp_edge);
    else n_pass++;
  endtask

  task automatic test_both_same_cycle();
    obs_t o;
    do_txn(2'd2, 2'd0, 1'b0, 2, 2, 1, 0, o);
    n_checks++;
    if (o.serr_n !== 1 || o.sack_n !== 0)
      $display("FAIL both_resp got serr=%0d sack=%0d want 1/0",
               o.serr_n, o.sack_n);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    do_txn(2'd1, 2'd2, 1'b0, 3, 1, 0, 0, o);
    n_checks++;
    if (o.resp_edge - (o.fcs_edge + 1) !== TO + 1)
      $display("FAIL tmo_lat got %0d want %0d",
               o.resp_edge - (o.fcs_edge + 1), TO + 1);
    else n_pass++;
    n_checks++;
    if (o.serr_n !== 1 || o.sack_n !== 0)
      $display("FAIL tmo_resp got serr=%0d sack=%0d want 1/0",
               o.serr_n, o.sack_n);
    else n_pass++;
    n_checks++;
    if (o.rel_vec[6:1] !== 6'b1_1111_0)
      $display("FAIL tmo_release got %b want 111110", o.rel_vec[6:1]);
    else n_pass++;
  endtask

  task automatic test_no_grant();
    obs_t o;
    do_txn(2'd2, 2'd0, 1'b1, 0, 1, 0, 20, o);
    n_checks++;
    if (o.pre_bad !== 1'b0)
      $display("FAIL nogrant_idle got %b want 0", o.pre_bad);
    else n_pass++;
    n_checks++;
    if (o.aoe_e0 !== 1'b1)
      $display("FAIL grant_start got %b want 1", o.aoe_e0);
    else n_pass++;
    n_checks++;
    if (o.fcs_edge !== AS || o.sack_n !== 1)
      $display("FAIL grant_cycle got fcs=%0d sack=%0d want %0d/1",
               o.fcs_edge, o.sack_n, AS);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    bus.SREQ    = 1'b1;
    bus.SSIZ    = 2'd2;
    bus.SA      = 2'd0;
    bus.SWRITE  = 1'b1;
    bus.MYBUS_n = 1'b0;
    repeat (AS + 2) @(negedge clk);
    n_checks++;
    if (bus.DOE !== 1'b1)
      $display("FAIL rstmid_wait got %b want 1", bus.DOE);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.AOE, bus.FCS_n, bus.DS_n, bus.DOE, bus.READ,
         bus.SACK, bus.SERR, bus.BUSY} !== 11'b0_1_1111_0_1_000)
      $display("FAIL rstmid_pins got %b want 01111101000",
               {bus.AOE, bus.FCS_n, bus.DS_n, bus.DOE, bus.READ,
                bus.SACK, bus.SERR, bus.BUSY});
    else n_pass++;
    @(negedge clk);
    rst         = 1'b0;
    bus.SREQ    = 1'b0;
    bus.MYBUS_n = 1'b1;
    @(negedge clk);
    do_txn(2'd0, 2'd3, 1'b0, 0, 1, 0, 0, o);
    n_checks++;
    if (o.sack_n !== 1 || o.resp_edge !== AS + 2 || o.ds_wait !== 4'b1110)
      $display("FAIL rstmid_next got sack=%0d lat=%0d ds=%b want 1/%0d/1110",
               o.sack_n, o.resp_edge, o.ds_wait, AS + 2);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t       o;
    logic [1:0] siz, sa;
    logic       wr;
    int         kind, dly, hold, gdly, nb, mask, h;
    int         e_resp, e_idle, e_fcs;
    bit         mis, ok;
    logic [3:0] e_ds;
    for (int i = 0; i < 24; i++) begin
      siz  = 2'($urandom_range(0, 3));
      sa   = 2'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      kind = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 2));
      if (i % 8 == 5) kind = 3;
      dly  = $urandom_range(1, 5);
      hold = $urandom_range(0, 3);
      nb   = (siz == 2'd0) ? 1 : (siz == 2'd1) ? 2 : 4;
      mis  = (int'(sa) % nb) != 0;
      gdly = mis ? 0 : int'($urandom_range(0, 2));
      e_ds = 4'hF;
      if (!mis) begin
        mask = ((1 << nb) - 1) << (4 - nb - int'(sa));
        e_ds = 4'(~mask);
      end
      ok     = !mis && kind == 0;
      e_fcs  = mis ? -1 : AS;
      e_resp = mis ? 0 : (kind == 3) ? AS + 1 + TO + 1 : AS + 1 + dly;
      h      = (mis || kind == 3) ? 0 : hold;
      e_idle = mis ? 1 : e_resp + ((h + 1 > 2) ? h + 1 : 2) + 1;
      do_txn(siz, sa, wr, kind, dly, hold, gdly, o);
      n_checks++;
      if (o.fcs_edge !== e_fcs)
        $display("FAIL rnd%0d fcs_edge got %0d want %0d", i, o.fcs_edge, e_fcs);
      else n_pass++;
      n_checks++;
      if (o.resp_edge !== e_resp)
        $display("FAIL rnd%0d resp_edge got %0d want %0d", i, o.resp_edge, e_resp);
      else n_pass++;
      n_checks++;
      if (o.sack_n !== int'(ok) || o.serr_n !== int'(!ok))
        $display("FAIL rnd%0d resp got sack=%0d serr=%0d want %0d/%0d",
                 i, o.sack_n, o.serr_n, ok, !ok);
      else n_pass++;
      n_checks++;
      if (o.doe_wait !== !mis)
        $display("FAIL rnd%0d doe got %b want %b", i, o.doe_wait, !mis);
      else n_pass++;
      if (!mis) begin
        n_checks++;
        if ({o.ds_wait, o.read_wait, o.aoe_wait} !== {e_ds, !wr, 1'b1})
          $display("FAIL rnd%0d lanes got %b want %b", i,
                   {o.ds_wait, o.read_wait, o.aoe_wait}, {e_ds, !wr, 1'b1});
        else n_pass++;
      end
      n_checks++;
      if (o.rel_vec !== 7'b1_1111_0_0)
        $display("FAIL rnd%0d release got %b want 1111100", i, o.rel_vec);
      else n_pass++;
      n_checks++;
      if (o.idle_edge !== e_idle)
        $display("FAIL rnd%0d idle_edge got %0d want %0d", i, o.idle_edge, e_idle);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.MYBUS_n = 1'b1;
    bus.SREQ    = 1'b0;
    bus.SWRITE  = 1'b0;
    bus.SSIZ    = 2'd0;
    bus.SA      = 2'd0;
    bus.DTACK_n = 1'b1;
    bus.BERR_n  = 1'b1;
    test_reset();
    test_long_read();
    test_byte_write();
    test_misaligned();
    test_both_same_cycle();
    test_timeout();
    test_no_grant();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
